iiitb_cg_ctrl: RTL and testbench

Clock-gating enable controller that sits directly upstream of the integrated clock-gating cell. It drives the ICG enable input `in`.
It watches the data inputs d0/d1 that feed the gated flops, plus an explicit wake request. After a programmable run of idle cycles it deasserts the enable, and it re-enables the clock on any activity.
It runs on the free-running (ungated) clock and also provides gating statistics for power bring-up.

---
 rtl/iiitb_cg_ctrl.sv | 132 +++++++++++++
 tb/tb_iiitb_cg_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_cg_ctrl.sv
// Clock-gating enable controller feeding the ICG `in` pin; runs on the free-running clock.
// Latency: en falls on the edge sampling the IDLE_CYCLES-th idle cycle; wakes one edge after activity.
// No backpressure: d0/d1 are only monitored, and all outputs are registered flops.
module iiitb_cg_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d0,
  input  logic              d1,
  input  logic              wake_req,
  input  logic              force_on,
  output logic              en,
  output logic              gated,
  output logic              wake_evt,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                d0_q, d0_d;
  logic                d1_q, d1_d;
  logic                en_q, en_d;
  logic                gated_q, gated_d;
  logic                wake_evt_q, wake_evt_d;
  logic [STAT_W-1:0]   gated_cycles_q, gated_cycles_d;
  logic                activity;

  // Any data edge on the monitored bits, an explicit wake, or a force counts as activity.
  assign activity = (d0 != d0_q) | (d1 != d1_q) | wake_req | force_on;

  // Next-state and registered-output computation; en only ever comes from a flop.
  always_comb begin
    state_d        = state_q;
    idle_cnt_d     = idle_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    d0_d           = d0;
    d1_d           = d1;
    en_d           = en_q;
    gated_d        = gated_q;
    wake_evt_d     = 1'b0;
    gated_cycles_d = gated_cycles_q;

    unique case (state_q)
      ST_RUN: begin
        if (activity) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = ST_GATED;
          idle_cnt_d = '0;
          en_d       = 1'b0;
          gated_d    = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_GATED: begin
        // Saturating statistic: stuck at all-ones rather than wrapping to a small value.
        if (gated_cycles_q != '1) begin
          gated_cycles_d = gated_cycles_q + STAT_W'(1);
        end
        if (activity) begin
          state_d    = ST_HOLD;
          en_d       = 1'b1;
          gated_d    = 1'b0;
          wake_evt_d = 1'b1;
          hold_cnt_d = HOLD_LAST;
        end
      end
      ST_HOLD: begin
        // Activity is deliberately ignored so the woken domain gets a guaranteed run window.
        if (hold_cnt_q == '0) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        en_d       = 1'b1;
        gated_d    = 1'b0;
      end
    endcase
  end

  // State register; reset forces en high asynchronously so downstream flops can initialise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      idle_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      d0_q           <= 1'b0;
      d1_q           <= 1'b0;
      en_q           <= 1'b1;
      gated_q        <= 1'b0;
      wake_evt_q     <= 1'b0;
      gated_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      d0_q           <= d0_d;
      d1_q           <= d1_d;
      en_q           <= en_d;
      gated_q        <= gated_d;
      wake_evt_q     <= wake_evt_d;
      gated_cycles_q <= gated_cycles_d;
    end
  end

  assign en           = en_q;
  assign gated        = gated_q;
  assign wake_evt     = wake_evt_q;
  assign gated_cycles = gated_cycles_q;

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Directed bench for iiitb_cg_ctrl: default instance plus a STAT_W=4 instance for saturation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Every scenario runs a fixed number of cycles, so the run always terminates.
module tb_iiitb_cg_ctrl;

  logic        clk;
  logic        rst;
  logic        d0;
  logic        d1;
  logic        wake_req;
  logic        force_on;
  logic        en;
  logic        gated;
  logic        wake_evt;
  logic [15:0] gated_cycles;
  logic        en4;
  logic        gated4;
  logic        wake_evt4;
  logic [3:0]  gated_cycles4;

  int checks = 0;
  int errors = 0;

  iiitb_cg_ctrl #(.IDLE_CYCLES(4), .HOLD_CYCLES(2), .STAT_W(16)) u_dut (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .wake_req(wake_req), .force_on(force_on),
    .en(en), .gated(gated), .wake_evt(wake_evt), .gated_cycles(gated_cycles)
  );

  iiitb_cg_ctrl #(.IDLE_CYCLES(4), .HOLD_CYCLES(2), .STAT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .wake_req(wake_req), .force_on(force_on),
    .en(en4), .gated(gated4), .wake_evt(wake_evt4), .gated_cycles(gated_cycles4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d0 = 1'b0; d1 = 1'b0; wake_req = 1'b0; force_on = 1'b0;
    step();
    step();
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL reset_en: got %b expected 1", en); end
    checks++;
    if (gated !== 1'b0) begin errors++; $display("FAIL reset_gated: got %b expected 0", gated); end
    checks++;
    if (wake_evt !== 1'b0) begin errors++; $display("FAIL reset_wake_evt: got %b expected 0", wake_evt); end
    checks++;
    if (gated_cycles !== 16'd0) begin errors++; $display("FAIL reset_gated_cycles: got %0d expected 0", gated_cycles); end
    rst = 1'b0;
  endtask

  task automatic test_idle_gating();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (en !== 1'b1) begin errors++; $display("FAIL idle_en_high edge %0d: got %b expected 1", i, en); end
    end
    step();
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL idle_en_fall: got %b expected 0", en); end
    checks++;
    if (gated !== 1'b1) begin errors++; $display("FAIL idle_gated: got %b expected 1", gated); end
    checks++;
    if (gated_cycles !== 16'd0) begin errors++; $display("FAIL idle_cnt_start: got %0d expected 0", gated_cycles); end
  endtask

  task automatic test_counter();
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) begin
        checks++;
        if (gated_cycles !== 16'd10) begin errors++; $display("FAIL cnt_10: got %0d expected 10", gated_cycles); end
      end
      if (i == 15) begin
        checks++;
        if (gated_cycles4 !== 4'd15) begin errors++; $display("FAIL cnt4_15: got %0d expected 15", gated_cycles4); end
      end
    end
    checks++;
    if (gated_cycles !== 16'd20) begin errors++; $display("FAIL cnt_20: got %0d expected 20", gated_cycles); end
    checks++;
    if (gated_cycles4 !== 4'd15) begin errors++; $display("FAIL cnt4_saturate: got %0d expected 15", gated_cycles4); end
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL cnt_still_gated: got %b expected 0", en); end
  endtask

  task automatic test_wake_data();
    d0 = ~d0;
    step();
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL wake_en: got %b expected 1", en); end
    checks++;
    if (wake_evt !== 1'b1) begin errors++; $display("FAIL wake_evt_pulse: got %b expected 1", wake_evt); end
    checks++;
    if (gated !== 1'b0) begin errors++; $display("FAIL wake_gated: got %b expected 0", gated); end
    step();
    checks++;
    if (wake_evt !== 1'b0) begin errors++; $display("FAIL wake_evt_clear: got %b expected 0", wake_evt); end
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL wake_en_hold: got %b expected 1", en); end
    for (int i = 3; i <= 6; i++) begin
      step();
      checks++;
      if (en !== 1'b1) begin errors++; $display("FAIL wake_window cycle %0d: got %b expected 1", i, en); end
    end
    step();
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL wake_regate: got %b expected 0", en); end
  endtask

  task automatic test_back_to_back();
    wake_req = 1'b1;
    d1 = ~d1;
    step();
    wake_req = 1'b0;
    checks++;
    if (wake_evt !== 1'b1 || en !== 1'b1) begin
      errors++; $display("FAIL b2b_wake: got wake_evt=%b en=%b expected 1 1", wake_evt, en);
    end
    step();
    checks++;
    if (wake_evt !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse: got %b expected 0", wake_evt); end
    for (int i = 3; i <= 6; i++) step();
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL b2b_window_end: got %b expected 1", en); end
    step();
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL b2b_regate: got %b expected 0", en); end
  endtask

  task automatic test_threshold_race();
    d0 = ~d0;
    step();
    step();
    step();
    step();
    step();
    step();
    d1 = ~d1;
    step();
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL race_activity_wins: got %b expected 1", en); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (en !== 1'b1) begin errors++; $display("FAIL race_restart edge %0d: got %b expected 1", i, en); end
    end
    step();
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL race_regate: got %b expected 0", en); end
  endtask

  task automatic test_force_on();
    force_on = 1'b1;
    step();
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL force_exit_gated: got %b expected 1", en); end
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (en !== 1'b1) begin errors++; $display("FAIL force_hold cycle %0d: got %b expected 1", i, en); end
    end
    force_on = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (en !== 1'b1) begin errors++; $display("FAIL force_release edge %0d: got %b expected 1", i, en); end
    end
    step();
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL force_release_gate: got %b expected 0", en); end
  endtask

  task automatic test_reset_mid_gated();
    step();
    step();
    step();
    checks++;
    if (gated !== 1'b1 || gated_cycles === 16'd0) begin
      errors++; $display("FAIL pre_reset_state: got gated=%b cnt=%0d expected gated=1 cnt>0", gated, gated_cycles);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL async_rst_en: got %b expected 1", en); end
    checks++;
    if (gated !== 1'b0) begin errors++; $display("FAIL async_rst_gated: got %b expected 0", gated); end
    checks++;
    if (gated_cycles !== 16'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d expected 0", gated_cycles); end
    checks++;
    if (gated_cycles4 !== 4'd0) begin errors++; $display("FAIL async_rst_cnt4: got %0d expected 0", gated_cycles4); end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_gating();
    test_counter();
    test_wake_data();
    test_back_to_back();
    test_threshold_race();
    test_force_on();
    test_reset_mid_gated();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
